interface_elastic_buffer: RTL and testbench

- Parametrised ready/valid elastic buffer carrying a data payload. Used at cache-interface boundaries (request/response/forward channels) to break timing paths and absorb back-pressure.
- Generalises the single-slot valid/ready controller to DEPTH entries of DATA_WIDTH bits.
- Adds occupancy reporting and a synchronous flush.
- in_ready never depends combinationally on out_ready.

---
 rtl/interface_elastic_buffer_pkg.sv | 19 +
 rtl/interface_elastic_buffer_mem.sv | 36 +++
 rtl/interface_elastic_buffer.sv | 123 ++++++++++++
 tb/tb_interface_elastic_buffer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/interface_elastic_buffer_pkg.sv
// Shared definitions for interface elastic buffers: default widths, the
// default occupancy type and a pointer increment with explicit wrap.
// No ports (package).
package interface_elastic_buffer_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 64;
  localparam int unsigned DEFAULT_DEPTH      = 2;
  localparam int unsigned DEFAULT_CNT_WIDTH  = $clog2(DEFAULT_DEPTH + 1);

  typedef logic [DEFAULT_CNT_WIDTH-1:0] eb_count_t;

  // Advance a ring pointer by one and wrap from depth-1 back to 0, so that
  // non-power-of-two depths never address past the last entry.
  function automatic int unsigned ptr_inc_wrap(input int unsigned ptr,
                                               input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/interface_elastic_buffer_mem.sv
// Storage array for the elastic buffer: DEPTH x DATA_WIDTH registers with one
// synchronous write port and one asynchronous read port. Contents are not reset.
// Ports:
//   clk      - clock, rising edge
//   wr_en    - write strobe
//   wr_ptr   - write address
//   wr_data  - write payload
//   rd_ptr   - read address
//   rd_data  - entry at rd_ptr (combinational)
module interface_elastic_buffer_mem
  import interface_elastic_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_ptr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]      rd_ptr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; payload storage needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/interface_elastic_buffer.sv
// Ready/valid elastic buffer with DEPTH entries, occupancy reporting and a
// synchronous flush. in_ready depends only on registered state and flush,
// never on out_ready.
// Optional build macro INTERFACE_ELASTIC_BUFFER_BYPASS_EN: when the buffer is
// empty, in_valid/in_data pass straight to out_valid/out_data (0 latency) and
// an item taken downstream in that same cycle is never written.
// Ports:
//   clk, rst     - clock (rising edge), asynchronous active-low reset
//   flush        - synchronous clear of all entries, blocks both handshakes
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and head payload
//   count        - current occupancy
//   full, empty  - count == DEPTH, count == 0
module interface_elastic_buffer
  import interface_elastic_buffer_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int unsigned DEPTH      = DEFAULT_DEPTH,
  localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_r, wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr_r, rd_ptr_nxt;
  logic [CNT_WIDTH-1:0]  count_r, count_nxt;
  logic                  push, pop;
  logic                  wr_en, rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
`ifdef INTERFACE_ELASTIC_BUFFER_BYPASS_EN
  logic                  bypass;
`endif

  interface_elastic_buffer_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr_r),
    .wr_data (in_data),
    .rd_ptr  (rd_ptr_r),
    .rd_data (rd_data)
  );

  // Handshake decode; wr_en/rd_en are the storage-side events.
  always_comb begin
    in_ready = !flush && (count_r < CNT_WIDTH'(DEPTH));
`ifdef INTERFACE_ELASTIC_BUFFER_BYPASS_EN
    bypass    = !flush && (count_r == '0);
    out_valid = bypass ? in_valid : (!flush && (count_r != '0));
    out_data  = bypass ? in_data : rd_data;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    // A pass-through item is consumed downstream without touching storage.
    wr_en     = push && !(bypass && out_ready);
    rd_en     = pop && !bypass;
`else
    out_valid = !flush && (count_r != '0);
    out_data  = rd_data;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    wr_en     = push;
    rd_en     = pop;
`endif
  end

  // Pointer and occupancy next state; flush overrides everything.
  always_comb begin
    wr_ptr_nxt = wr_ptr_r;
    rd_ptr_nxt = rd_ptr_r;
    count_nxt  = count_r;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_nxt = PTR_W'(ptr_inc_wrap(32'(wr_ptr_r), DEPTH));
      end
      if (rd_en) begin
        rd_ptr_nxt = PTR_W'(ptr_inc_wrap(32'(rd_ptr_r), DEPTH));
      end
      case ({wr_en, rd_en})
        2'b10:   count_nxt = count_r + CNT_WIDTH'(1);
        2'b01:   count_nxt = count_r - CNT_WIDTH'(1);
        default: count_nxt = count_r;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt;
      rd_ptr_r <= rd_ptr_nxt;
      count_r  <= count_nxt;
    end
  end

  assign count = count_r;
  assign full  = (count_r == CNT_WIDTH'(DEPTH));
  assign empty = (count_r == '0);

endmodule

// File: tb/tb_interface_elastic_buffer.sv
// Directed bench for interface_elastic_buffer: a DEPTH=2 and a DEPTH=3
// instance share stimulus; one is checked at a time against a queue model.
module tb_interface_elastic_buffer;

  localparam int unsigned DW = 16;
`ifdef INTERFACE_ELASTIC_BUFFER_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;

  logic          d2_in_ready, d2_out_valid, d2_full, d2_empty;
  logic [DW-1:0] d2_out_data;
  logic [1:0]    d2_count;
  logic          d3_in_ready, d3_out_valid, d3_full, d3_empty;
  logic [DW-1:0] d3_out_data;
  logic [1:0]    d3_count;

  interface_elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(2)) u_dut2 (
    .clk (clk), .rst (rst), .flush (flush),
    .in_valid (in_valid), .in_ready (d2_in_ready), .in_data (in_data),
    .out_valid (d2_out_valid), .out_ready (out_ready), .out_data (d2_out_data),
    .count (d2_count), .full (d2_full), .empty (d2_empty)
  );

  interface_elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(3)) u_dut3 (
    .clk (clk), .rst (rst), .flush (flush),
    .in_valid (in_valid), .in_ready (d3_in_ready), .in_data (in_data),
    .out_valid (d3_out_valid), .out_ready (out_ready), .out_data (d3_out_data),
    .count (d3_count), .full (d3_full), .empty (d3_empty)
  );

  always #5 clk = ~clk;

  int            depth = 2;
  int            n_tests = 0;
  int            n_fail = 0;
  int            npops = 0;
  logic [DW-1:0] q[$];

  logic          o_ir, o_ov, o_full, o_empty;
  logic [DW-1:0] o_od;
  logic [1:0]    o_cnt;

  assign o_ir    = (depth == 2) ? d2_in_ready  : d3_in_ready;
  assign o_ov    = (depth == 2) ? d2_out_valid : d3_out_valid;
  assign o_od    = (depth == 2) ? d2_out_data  : d3_out_data;
  assign o_cnt   = (depth == 2) ? d2_count     : d3_count;
  assign o_full  = (depth == 2) ? d2_full      : d3_full;
  assign o_empty = (depth == 2) ? d2_empty     : d3_empty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    q.delete();
    chk("rst_in_ready",  32'(o_ir),    32'd1);
    chk("rst_out_valid", 32'(o_ov),    32'd0);
    chk("rst_count",     32'(o_cnt),   32'd0);
    chk("rst_full",      32'(o_full),  32'd0);
    chk("rst_empty",     32'(o_empty), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One cycle: drive at negedge, check against the model, then take the edge.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy,
                      input logic fl, output logic pushed);
    logic          by, e_ir, e_ov, popped;
    logic [DW-1:0] e_od;
    int            mcount;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
    mcount = q.size();
    by   = BYPASS_EN && !fl && (mcount == 0);
    e_ir = !fl && (mcount < depth);
    e_ov = by ? iv : (!fl && (mcount != 0));
    e_od = by ? id : ((mcount != 0) ? q[0] : '0);
    chk("in_ready",  32'(o_ir),    32'(e_ir));
    chk("out_valid", 32'(o_ov),    32'(e_ov));
    if (e_ov) chk("out_data", 32'(o_od), 32'(e_od));
    chk("count",     32'(o_cnt),   32'(mcount));
    chk("full",      32'(o_full),  32'(mcount == depth));
    chk("empty",     32'(o_empty), 32'(mcount == 0));
    pushed = iv && e_ir;
    popped = e_ov && ordy;
    if (fl) begin
      q.delete();
    end else if (!(by && pushed && popped)) begin
      if (popped) void'(q.pop_front());
      if (pushed) q.push_back(id);
    end
    if (popped) npops++;
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic p;
    int   idx;
    int   cyc;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // DEPTH=2: fill, hold at full, drain.
    depth = 2;
    do_reset();
    step(1'b1, 16'h000A, 1'b0, 1'b0, p);
    step(1'b1, 16'h000B, 1'b0, 1'b0, p);
    step(1'b0, 16'h0000, 1'b0, 1'b0, p);
    step(1'b0, 16'h0000, 1'b1, 1'b0, p);
    step(1'b0, 16'h0000, 1'b1, 1'b0, p);
    step(1'b0, 16'h0000, 1'b0, 1'b0, p);

    // Full with simultaneous push attempt and pop: only the pop happens.
    step(1'b1, 16'h0001, 1'b0, 1'b0, p);
    step(1'b1, 16'h0002, 1'b0, 1'b0, p);
    step(1'b1, 16'h0003, 1'b1, 1'b0, p);
    chk("full_push_blocked", 32'(p), 32'd0);
    step(1'b1, 16'h0003, 1'b0, 1'b0, p);
    chk("freed_slot_push", 32'(p), 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, p);

    // Flush at count=2 with both handshakes requested.
    step(1'b1, 16'h000D, 1'b1, 1'b1, p);
    step(1'b0, 16'h0000, 1'b0, 1'b0, p);

    // Empty-buffer latency (0 with bypass, 1 without), then drain.
    step(1'b1, 16'h0055, 1'b1, 1'b0, p);
    step(1'b0, 16'h0000, 1'b1, 1'b0, p);
    step(1'b0, 16'h0000, 1'b0, 1'b0, p);

    // Empty, downstream stalled: item must be stored either way.
    step(1'b1, 16'h0066, 1'b0, 1'b0, p);
    step(1'b1, 16'h0077, 1'b0, 1'b0, p);

    // Asynchronous reset with the buffer full.
    do_reset();
    step(1'b0, 16'h0000, 1'b1, 1'b0, p);

    // DEPTH=3: stream 10 items with out_ready toggling 1,0,1,0...
    depth = 3;
    do_reset();
    npops = 0;
    idx = 0;
    cyc = 0;
    while ((idx < 10 || q.size() != 0) && cyc < 200) begin
      step(idx < 10, 16'(32'h10 + idx), (cyc % 2) == 0, 1'b0, p);
      if (p) idx++;
      cyc++;
    end
    chk("stream_in_done",  32'(cyc < 200), 32'd1);
    chk("stream_pushed",   32'(idx),       32'd10);
    chk("stream_popped",   32'(npops),     32'd10);
    step(1'b0, 16'h0000, 1'b0, 1'b0, p);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
